// File: rtl/pkt_push_arbiter_if.sv
// Requester fan-in plus FIFO push bundle for pkt_push_arbiter.
// slave: the arbiter side; master: the requesters / FIFO side.
interface pkt_push_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [32*NUM_REQ-1:0]  req_id;
   logic [128*NUM_REQ-1:0] req_src;
   logic [128*NUM_REQ-1:0] req_dest;
   logic [128*NUM_REQ-1:0] req_payload;
   logic                   fifo_full;
   logic                   push;
   logic [31:0]            id;
   logic [127:0]           src;
   logic [127:0]           dest;
   logic [127:0]           payload;
   logic [GW-1:0]          grant_idx;
   logic                   locked;

   modport slave (
      input  req_valid, req_id, req_src, req_dest, req_payload, fifo_full,
      output req_ready, push, id, src, dest, payload, grant_idx, locked
   );

   modport master (
      output req_valid, req_id, req_src, req_dest, req_payload, fifo_full,
      input  req_ready, push, id, src, dest, payload, grant_idx, locked
   );
endinterface

// File: rtl/pkt_push_arbiter.sv
// Round-robin / burst-lock arbiter sharing the packet FIFO push port; PKT_ARB_STATS_EN adds per-requester grant counters.
// Accept-to-push latency is 1 cycle; the output slot holds while fifo_full is high and req_ready stays low until the slot can load.
module pkt_push_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pkt_push_arbiter_if.slave      bus
`ifdef PKT_ARB_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [32*NUM_REQ-1:0]  grant_count
`endif
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {ST_ARB, ST_LOCK} state_t;

   typedef struct packed {
      logic [31:0]  id;
      logic [127:0] src;
      logic [127:0] dest;
      logic [127:0] payload;
   } pkt_t;

   state_t        state_q, state_d;
   logic [GW-1:0] rr_q, rr_d;
   logic [GW-1:0] owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_q;
   pkt_t          pkt_q, win_pkt;
   logic [GW-1:0] grant_q;

   logic          drain, can_load, accept, win_vld, owner_vld;
   logic [GW-1:0] win_idx, scan_base, cand;
   int            idx;

   function automatic logic [GW-1:0] inc_mod(input logic [GW-1:0] x);
      return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
   endfunction

   assign drain     = push_q && !bus.fifo_full;
   assign can_load  = !push_q || drain;
   assign owner_vld = (state_q == ST_LOCK) && bus.req_valid[owner_q];
   assign accept    = win_vld && can_load;

   // A lock whose owner went idle scans from owner+1 in the same cycle, so no bubble.
   always_comb begin
      win_vld   = 1'b0;
      win_idx   = '0;
      idx       = 0;
      cand      = '0;
      scan_base = (state_q == ST_LOCK) ? inc_mod(owner_q) : rr_q;
      if (owner_vld) begin
         win_vld = 1'b1;
         win_idx = owner_q;
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(scan_base) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = GW'(idx);
            if (bus.req_valid[cand]) begin
               win_vld = 1'b1;
               win_idx = cand;
            end
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (accept && rst_n) bus.req_ready[win_idx] = 1'b1;
   end

   always_comb begin
      win_pkt.id      = bus.req_id[32*win_idx +: 32];
      win_pkt.src     = bus.req_src[128*win_idx +: 128];
      win_pkt.dest    = bus.req_dest[128*win_idx +: 128];
      win_pkt.payload = bus.req_payload[128*win_idx +: 128];
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      if (can_load) begin
         if (owner_vld) begin
            // This accept brings the burst to MAX_BURST.
            if (cnt_q == CW'(MAX_BURST - 1)) begin
               state_d = ST_ARB;
               rr_d    = inc_mod(owner_q);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            if (state_q == ST_LOCK) begin
               state_d = ST_ARB;
               rr_d    = inc_mod(owner_q);
               cnt_d   = '0;
            end
            if (win_vld) begin
               if (MAX_BURST > 1) begin
                  state_d = ST_LOCK;
                  owner_d = win_idx;
                  cnt_d   = CW'(1);
               end else begin
                  rr_d = inc_mod(win_idx);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ARB;
         rr_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         push_q  <= 1'b0;
         pkt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            push_q  <= 1'b1;
            pkt_q   <= win_pkt;
            grant_q <= win_idx;
         end else if (drain) begin
            push_q <= 1'b0;
         end
      end
   end

   assign bus.push      = push_q;
   assign bus.id        = pkt_q.id;
   assign bus.src       = pkt_q.src;
   assign bus.dest      = pkt_q.dest;
   assign bus.payload   = pkt_q.payload;
   assign bus.grant_idx = grant_q;
   assign bus.locked    = (state_q == ST_LOCK);

`ifdef PKT_ARB_STATS_EN
   logic [31:0] gcnt_q [NUM_REQ];

   // Clear wins over a same-cycle accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (stats_clr)                           gcnt_q[i] <= '0;
            else if (accept && win_idx == GW'(i))    gcnt_q[i] <= gcnt_q[i] + 32'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) grant_count[32*i +: 32] = gcnt_q[i];
   end
`endif
endmodule

// File: doc/pkt_push_arbiter.md
Name: pkt_push_arbiter

Overview:
- Shares the single push port of the packet FIFO among NUM_REQ packet sources.
- Arbitration is round-robin with optional burst locking. One packet is accepted per cycle.
- Accepted packets go into a one-entry output register, which drives the FIFO push interface. The register holds its contents while the FIFO reports full.
- Sits directly upstream of the packet FIFO. Its outputs connect 1:1 to the FIFO's push, id, src, dest and payload inputs.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- MAX_BURST, 4, maximum back-to-back packets one requester may send while holding the lock; 1 disables locking.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_ready  out  NUM_REQ  per-requester accept; transfer occurs when req_valid[i] && req_ready[i].
- req_id  in  32*NUM_REQ  packed ids; requester i occupies [32*i +: 32].
- req_src  in  128*NUM_REQ  packed source fields.
- req_dest  in  128*NUM_REQ  packed destination fields.
- req_payload  in  128*NUM_REQ  packed payloads.
- fifo_full  in  1  FIFO full flag.
- push  out  1  FIFO push strobe (output register valid).
- id  out  32  packet id to FIFO.
- src  out  128  packet src to FIFO.
- dest  out  128  packet dest to FIFO.
- payload  out  128  packet payload to FIFO.
- grant_idx  out  $clog2(NUM_REQ)  index of the requester whose packet is in the output register.
- locked  out  1  high while the FSM is in LOCK.

Behaviour:
- Reset (asynchronous, rst_n low):
  - push=0; id, src, dest, payload = 0; grant_idx=0; locked=0; req_ready=0.
  - FSM=ARB; rr_ptr=0; burst_cnt=0.
- Output slot:
  - drain = push && !fifo_full.
  - can_load = !push || drain.
  - push and all fields stay stable until drain.
- req_ready is combinational: at most one bit is high, and only when can_load is high.
- Latency: a packet accepted in cycle N is presented on push in cycle N+1. With fifo_full low it is pushed into the FIFO in cycle N+1.
- FSM ARB:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=can_load.
  - On accept with MAX_BURST>1: go to LOCK; owner=winner; burst_cnt=1.
  - On accept with MAX_BURST=1: stay in ARB; rr_ptr=winner+1 mod NUM_REQ.
- FSM LOCK:
  - Only the owner is eligible.
  - On each accept: burst_cnt++.
  - When burst_cnt reaches MAX_BURST: go to ARB; rr_ptr=owner+1.
  - If req_valid[owner] is low in a cycle: go to ARB and set rr_ptr=owner+1. In that same cycle, round-robin arbitration among the others is performed using rr_ptr=owner+1, with no bubble.
  - While can_load is low, the lock and burst_cnt hold.
- No requesters valid: req_ready=0; state holds (ARB) or exits per the LOCK rules above.
- fifo_full high for any duration: no accepts, no loss, no duplication. Resumes on the first cycle with fifo_full low.
- Simultaneous drain and load in one cycle: the new packet replaces the old; push stays high.
- Reset mid-burst or mid-hold: the pending packet is discarded, and all state returns to its reset values.
- rr_ptr arithmetic is modulo NUM_REQ. For non-power-of-2 NUM_REQ, values >= NUM_REQ are never produced.

Optional Feature:
- Macro: PKT_ARB_STATS_EN.
- Defined:
  - Adds output grant_count, width 32*NUM_REQ, with one counter per requester.
  - Each counter increments on every accept from that requester and wraps at 2^32.
  - Counters reset to 0 on rst_n.
  - Adds input stats_clr, which synchronously zeros all counters. If stats_clr and an accept occur in the same cycle, that counter becomes 0.
- Undefined: neither port exists, and no counter logic is present.

Test Plan:
- Round-robin: NUM_REQ=4, MAX_BURST=1, all four req_valid held high, fifo_full=0 → accept order 0,1,2,3,0,...; push high every cycle from cycle 1.
- Burst lock: MAX_BURST=4, req 1 and req 2 continuously valid → accepts 1,1,1,1,2,2,2,2,1...; locked high during each run.
- Early release: MAX_BURST=4, req 0 valid for 2 packets then drops, req 3 valid → 0,0,3 with no idle cycle between the second 0 and the 3.
- Backpressure: fifo_full=1 for 5 cycles with id=0x55 in the slot → push and id stay constant, req_ready=0 for all five cycles; on release 0x55 is pushed exactly once, then the next packet follows.
- Async reset: assert rst_n low mid-burst (burst_cnt=2, push=1) → push=0, locked=0 immediately; first post-reset grant comes from requester 0 when it is valid.
- Stats (PKT_ARB_STATS_EN): 10 accepts from req 2, then stats_clr pulse → grant_count[2] reads 10, then 0.
